// File: rtl/mine_hit_tracker_pkg.sv
// mine_hit_tracker_pkg
// Shared definitions for the minefield and its hit tracker: mine count,
// row-index scrambling constant, flash FSM encodings and the helper that
// maps raster rows onto mine indices.
package mine_hit_tracker_pkg;

    localparam int          NUM_MINES    = 16;
    localparam logic [3:0]  MINE_IDX_XOR = 4'd8;

    typedef enum logic {
        FLASH_IDLE = 1'b0,
        FLASH_ON   = 1'b1
    } flash_state_t;

    // Mine row selected by vpos[6:3]; the XOR matches the minefield's row order.
    function automatic logic [3:0] mine_idx(input logic [3:0] row_bits);
        return row_bits ^ MINE_IDX_XOR;
    endfunction

endpackage

// File: rtl/mine_hit_tracker_frame_timer.sv
// frame_timer
// Vertical-sync rising-edge detector plus the flash frame down-counter.
// Ports:
//   clk, reset   : pixel clock, synchronous active-high reset
//   vsync        : vertical sync from the sync generator
//   load         : reload the counter with FLASH_FRAMES-1
//   vsync_rise   : high for the cycle in which vsync rises (frame boundary)
//   done         : counter has reached zero
module frame_timer #(
    parameter int FLASH_FRAMES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    input  logic load,
    output logic vsync_rise,
    output logic done
);

    localparam logic [7:0] LOAD_VAL = 8'(FLASH_FRAMES - 1);

    logic       vsync_q_r;
    logic [7:0] frame_cnt_r;

    assign vsync_rise = vsync && !vsync_q_r;
    assign done       = (frame_cnt_r == 8'd0);

    // vsync delay stage and frame counter; vsync_q resets high so a vsync
    // already high at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q_r   <= 1'b1;
            frame_cnt_r <= 8'd0;
        end else begin
            vsync_q_r <= vsync;
            if (load) begin
                frame_cnt_r <= LOAD_VAL;
            end else if (vsync_rise && (frame_cnt_r != 8'd0)) begin
                frame_cnt_r <= frame_cnt_r - 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

endmodule

// File: rtl/mine_hit_tracker.sv
// mine_hit_tracker
// Detects tank/mine pixel coincidences during a frame, then at the vsync
// boundary commits them into the exploded-mine mask, pulses per-player hit
// flags, bumps saturating per-player hit counts and starts a frame-counted
// explosion flash.
// Build option: MINE_REARM_EN -- when defined, a fully exploded minefield
// clears back to all-armed at the end of the flash.
// Ports:
//   clk, reset        : pixel clock, synchronous active-high reset
//   hpos, vpos        : raster position
//   vsync             : vertical sync, rising edge = frame boundary
//   mine_all          : mine pixel regardless of exploded state
//   tank1_gfx/2_gfx   : tank pixels
//   mine_exploded     : per-mine exploded mask (1 = hidden)
//   hit_p1/hit_p2     : one-cycle pulse at commit if that player hit a mine
//   flash             : explosion flash active
//   hits_p1/hits_p2   : saturating per-player hit-frame counts
module mine_hit_tracker
    import mine_hit_tracker_pkg::*;
#(
    parameter int FLASH_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  hpos,
    input  logic [8:0]  vpos,
    input  logic        vsync,
    input  logic        mine_all,
    input  logic        tank1_gfx,
    input  logic        tank2_gfx,
    output logic [15:0] mine_exploded,
    output logic        hit_p1,
    output logic        hit_p2,
    output logic        flash,
    output logic [7:0]  hits_p1,
    output logic [7:0]  hits_p2
);

    logic [NUM_MINES-1:0] mine_exploded_r;
    logic [NUM_MINES-1:0] pend_mask_r;
    logic                 pend_p1_r;
    logic                 pend_p2_r;
    logic                 hit_p1_r;
    logic                 hit_p2_r;
    logic [7:0]           hits_p1_r;
    logic [7:0]           hits_p2_r;
    flash_state_t         state_r;
    flash_state_t         state_next_s;

    logic [3:0]           idx_s;
    logic                 mine_live_s;
    logic                 hit1_s;
    logic                 hit2_s;
    logic [NUM_MINES-1:0] hit_mask_s;
    logic                 vsync_rise_s;
    logic                 done_s;
    logic                 load_s;
    logic                 commit_hits_s;
    logic                 rearm_s;
    logic                 unused_s;

    // Horizontal position and the vpos bits outside the mine row field are
    // not needed; hit detection keys on the mine/tank pixel coincidence.
    assign unused_s = &{1'b0, hpos, vpos[8:7], vpos[2:0]};

    assign idx_s         = mine_idx(vpos[6:3]);
    assign mine_live_s   = mine_all && !mine_exploded_r[idx_s];
    assign hit1_s        = mine_live_s && tank1_gfx;
    assign hit2_s        = mine_live_s && tank2_gfx;
    assign hit_mask_s    = (hit1_s || hit2_s) ? (16'd1 << idx_s) : 16'd0;
    assign commit_hits_s = vsync_rise_s && (pend_mask_r != 16'd0);

    frame_timer #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .load       (load_s),
        .vsync_rise (vsync_rise_s),
        .done       (done_s)
    );

    // Flash FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FLASH_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Flash FSM next state; a commit with hits (re)loads the frame counter.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            FLASH_IDLE: begin
                if (commit_hits_s) begin
                    state_next_s = FLASH_ON;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = FLASH_IDLE;
                end
            end
            FLASH_ON: begin
                if (commit_hits_s) begin
                    state_next_s = FLASH_ON;
                    load_s       = 1'b1;
                end else if (vsync_rise_s && done_s) begin
                    state_next_s = FLASH_IDLE;
                end else begin
                    state_next_s = FLASH_ON;
                end
            end
            default: begin
                state_next_s = FLASH_IDLE;
            end
        endcase
    end

    // Re-arm decision at the end of a flash over a fully exploded field.
    always_comb begin
`ifdef MINE_REARM_EN
        if ((state_r == FLASH_ON) && (state_next_s == FLASH_IDLE) &&
            (mine_exploded_r == 16'hFFFF)) begin
            rearm_s = 1'b1;
        end else begin
            rearm_s = 1'b0;
        end
`else
        rearm_s = 1'b0;
`endif
    end

    // Pending-hit capture during the frame and commit at the vsync boundary.
    // A hit pixel on the commit cycle itself is dropped with the pending state.
    always_ff @(posedge clk) begin
        if (reset) begin
            mine_exploded_r <= 16'd0;
            pend_mask_r     <= 16'd0;
            pend_p1_r       <= 1'b0;
            pend_p2_r       <= 1'b0;
            hit_p1_r        <= 1'b0;
            hit_p2_r        <= 1'b0;
            hits_p1_r       <= 8'd0;
            hits_p2_r       <= 8'd0;
        end else if (vsync_rise_s) begin
            mine_exploded_r <= rearm_s ? 16'd0 : (mine_exploded_r | pend_mask_r);
            hit_p1_r        <= pend_p1_r;
            hit_p2_r        <= pend_p2_r;
            if (pend_p1_r && (hits_p1_r != 8'd255)) begin
                hits_p1_r <= hits_p1_r + 8'd1;
            end else begin
                hits_p1_r <= hits_p1_r;
            end
            if (pend_p2_r && (hits_p2_r != 8'd255)) begin
                hits_p2_r <= hits_p2_r + 8'd1;
            end else begin
                hits_p2_r <= hits_p2_r;
            end
            pend_mask_r <= 16'd0;
            pend_p1_r   <= 1'b0;
            pend_p2_r   <= 1'b0;
        end else begin
            pend_mask_r <= pend_mask_r | hit_mask_s;
            pend_p1_r   <= pend_p1_r | hit1_s;
            pend_p2_r   <= pend_p2_r | hit2_s;
            hit_p1_r    <= 1'b0;
            hit_p2_r    <= 1'b0;
        end
    end

    assign mine_exploded = mine_exploded_r;
    assign hit_p1        = hit_p1_r;
    assign hit_p2        = hit_p2_r;
    assign hits_p1       = hits_p1_r;
    assign hits_p2       = hits_p2_r;
    assign flash         = (state_r == FLASH_ON);

endmodule

// File: tb/tb_mine_hit_tracker.sv
// tb_mine_hit_tracker
// Scoreboard bench: every vsync commit pushes the expected outputs for the
// commit cycle and the cycle after it; a negedge monitor pops and compares.
module tb_mine_hit_tracker;

    localparam int FF = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        vsync;
    logic        mine_all;
    logic        tank1_gfx;
    logic        tank2_gfx;
    logic [15:0] mine_exploded;
    logic        hit_p1;
    logic        hit_p2;
    logic        flash;
    logic [7:0]  hits_p1;
    logic [7:0]  hits_p2;

    mine_hit_tracker #(.FLASH_FRAMES(FF)) dut (
        .clk           (clk),
        .reset         (reset),
        .hpos          (hpos),
        .vpos          (vpos),
        .vsync         (vsync),
        .mine_all      (mine_all),
        .tank1_gfx     (tank1_gfx),
        .tank2_gfx     (tank2_gfx),
        .mine_exploded (mine_exploded),
        .hit_p1        (hit_p1),
        .hit_p2        (hit_p2),
        .flash         (flash),
        .hits_p1       (hits_p1),
        .hits_p2       (hits_p2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] mask;
        logic        h1;
        logic        h2;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic        fl;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [15:0] m_mask = 16'd0;
    logic [15:0] m_pend = 16'd0;
    logic        m_p1 = 1'b0;
    logic        m_p2 = 1'b0;
    int          m_c1 = 0;
    int          m_c2 = 0;
    int          m_rem = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // pop every entry whose due cycle has arrived
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            check_val("sb_due", cyc, mon_e.due);
            check_val("mine_exploded", mine_exploded, mon_e.mask);
            check_val("hit_p1", hit_p1, mon_e.h1);
            check_val("hit_p2", hit_p2, mon_e.h2);
            check_val("hits_p1", hits_p1, mon_e.c1);
            check_val("hits_p2", hits_p2, mon_e.c2);
            check_val("flash", flash, mon_e.fl);
        end
    end

    function automatic exp_t mk(input int due, input logic h1, input logic h2);
        exp_t e;
        e.due  = due;
        e.mask = m_mask;
        e.h1   = h1;
        e.h2   = h2;
        e.c1   = 8'(m_c1);
        e.c2   = 8'(m_c2);
        e.fl   = (m_rem > 0);
        return e;
    endfunction

    function automatic logic [8:0] vpos_of(input int i);
        return 9'(((i ^ 8) * 8) + 2);
    endfunction

    // one pixel of stimulus; model records a hit on a live mine
    task automatic pixel(input logic [8:0] v, input logic m, input logic t1, input logic t2);
        int idx;
        idx = ((int'(v) / 8) % 16) ^ 8;
        if (m && !m_mask[idx] && (t1 || t2)) begin
            m_pend[idx] = 1'b1;
            if (t1) m_p1 = 1'b1;
            if (t2) m_p2 = 1'b1;
        end
        vpos = v; hpos = 9'd84; mine_all = m; tank1_gfx = t1; tank2_gfx = t2;
        @(posedge clk); #1;
        mine_all = 1'b0; tank1_gfx = 1'b0; tank2_gfx = 1'b0;
    endtask

    // one vsync pulse: model the commit and queue expectations
    task automatic do_frame();
        logic [15:0] nm;
        logic        e1;
        logic        e2;
        nm = m_mask | m_pend;
        e1 = m_p1;
        e2 = m_p2;
        if (m_p1 && m_c1 < 255) m_c1++;
        if (m_p2 && m_c2 < 255) m_c2++;
        if (m_pend != 16'd0) begin
            m_rem = FF;
        end else if (m_rem > 0) begin
            m_rem--;
`ifdef MINE_REARM_EN
            if (m_rem == 0 && nm == 16'hFFFF) nm = 16'd0;
`endif
        end
        m_mask = nm;
        m_pend = 16'd0;
        m_p1 = 1'b0;
        m_p2 = 1'b0;
        sb_q.push_back(mk(cyc + 1, e1, e2));
        sb_q.push_back(mk(cyc + 2, 1'b0, 1'b0));
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_mask = 16'd0; m_pend = 16'd0; m_p1 = 1'b0; m_p2 = 1'b0;
        m_c1 = 0; m_c2 = 0; m_rem = 0;
        sb_q.push_back(mk(cyc, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; vsync = 1'b1; hpos = 9'd0; vpos = 9'd0;
        mine_all = 1'b0; tank1_gfx = 1'b0; tank2_gfx = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // vsync still high after release: no commit, outputs stay reset
        sb_q.push_back(mk(cyc, 1'b0, 1'b0));
        sb_q.push_back(mk(cyc + 1, 1'b0, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        vsync = 1'b0;
        @(posedge clk); #1;
        do_frame();                         // empty frame

        pixel(9'd66, 1'b1, 1'b1, 1'b0);     // tank1 on mine 0
        do_frame();
        for (int i = 0; i < FF; i++) do_frame();  // flash drops on the 4th rise

        pixel(9'd66, 1'b1, 1'b1, 1'b0);     // already exploded: ignored
        pixel(9'd90, 1'b0, 1'b1, 1'b1);     // tanks but no mine pixel
        do_frame();

        pixel(vpos_of(5), 1'b1, 1'b1, 1'b0);
        do_reset();                         // pending hit abandoned
        do_frame();

        pixel(9'd66, 1'b1, 1'b1, 1'b0);     // mine 0, tank1
        pixel(9'd90, 1'b1, 1'b0, 1'b1);     // mine 3, tank2
        do_frame();

        pixel(vpos_of(7), 1'b1, 1'b1, 1'b1);  // both tanks, same mine
        do_frame();

        pixel(vpos_of(1), 1'b1, 1'b1, 1'b0);  // two mines, one count
        pixel(vpos_of(2), 1'b1, 1'b1, 1'b0);
        do_frame();

        // remaining mines, two per frame, reloading the flash each time
        pixel(vpos_of(4), 1'b1, 1'b0, 1'b1);
        pixel(vpos_of(5), 1'b1, 1'b0, 1'b1);
        do_frame();
        pixel(vpos_of(6), 1'b1, 1'b0, 1'b1);
        pixel(vpos_of(8), 1'b1, 1'b0, 1'b1);
        do_frame();
        for (int i = 9; i < 16; i += 2) begin
            pixel(vpos_of(i), 1'b1, 1'b0, 1'b1);
            pixel(vpos_of(i + 1 > 15 ? 15 : i + 1), 1'b1, 1'b0, 1'b1);
            do_frame();
        end
        for (int i = 0; i < FF + 2; i++) do_frame();  // field full; flash expires

        @(negedge clk); #1;
        check_val("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
